// File: rtl/dot_matrix_scan_ctrl_if.sv
// rtl/dot_matrix_scan_ctrl_if.sv - write/commit/scroll controls and matrix drive signals
interface dot_matrix_scan_ctrl_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    localparam int RW = $clog2(ROWS);

    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;
    logic            commit;
    logic            scroll_en;
    logic            scroll_dir;
    logic [RW-1:0]   row_bin;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col;
    logic            frame_start;
    logic            swap_pending;

    modport master (
        output wr_en, wr_row, wr_data, commit, scroll_en, scroll_dir,
        input  row_bin, row_sel, col, frame_start, swap_pending
    );

    modport slave (
        input  wr_en, wr_row, wr_data, commit, scroll_en, scroll_dir,
        output row_bin, row_sel, col, frame_start, swap_pending
    );
endinterface

// File: rtl/dot_matrix_scan_ctrl.sv
// rtl/dot_matrix_scan_ctrl.sv - double-buffered LED dot-matrix row scanner with frame-synchronous swap and scroll
module dot_matrix_scan_ctrl #(
    parameter int ROWS          = 16,
    parameter int COLS          = 16,
    parameter int SCAN_DIV      = 1000,
    parameter int SCROLL_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dot_matrix_scan_ctrl_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(SCROLL_FRAMES + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(COLS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(SCROLL_FRAMES - 1);
    localparam logic [RW:0]   ROWS_W   = (RW + 1)'(ROWS);
    localparam logic [CW:0]   COLS_W   = (CW + 1)'(COLS);

    logic [DW-1:0]   div_q;
    logic [RW-1:0]   row_q;
    logic            fs_q;
    logic            front_q;
    logic            pend_q;
    logic [CW-1:0]   off_q;
    logic [FW-1:0]   frm_q;
    logic [COLS-1:0] bank_q [2][ROWS];

    logic            row_tc;
    logic            frame_tc;
    logic            wr_ok;
    logic [COLS-1:0] cur_row;

    assign row_tc   = (div_q == DIV_LAST);
    assign frame_tc = row_tc && (row_q == ROW_LAST);
    assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_row} < ROWS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            row_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= frame_tc;
            if (row_tc) begin
                div_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // Writes always target the bank that is back before this edge, so a write
    // coinciding with a swap lands in the bank that becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                bank_q[0][r] <= '0;
                bank_q[1][r] <= '0;
            end
        end else if (wr_ok) begin
            bank_q[~front_q][bus.wr_row] <= bus.wr_data;
        end
    end

    // A commit on the boundary cycle is held for the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q <= 1'b0;
            pend_q  <= 1'b0;
        end else if (frame_tc && pend_q) begin
            front_q <= ~front_q;
            pend_q  <= 1'b0;
        end else if (bus.commit) begin
            pend_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= '0;
            frm_q <= '0;
        end else if (frame_tc && bus.scroll_en) begin
            if (frm_q == FRM_LAST) begin
                frm_q <= '0;
                if (bus.scroll_dir)
                    off_q <= (off_q == '0) ? OFF_LAST : off_q - 1'b1;
                else
                    off_q <= (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
            end else begin
                frm_q <= frm_q + 1'b1;
            end
        end
    end

    // Outputs derive from registered state only, so row, select and column
    // data always change on the same edge.
    assign cur_row          = bank_q[front_q][row_q];
    assign bus.col          = (cur_row << off_q) | (cur_row >> (COLS_W - {1'b0, off_q}));
    assign bus.row_bin      = row_q;
    assign bus.row_sel      = {{(ROWS - 1){1'b0}}, 1'b1} << row_q;
    assign bus.frame_start  = fs_q;
    assign bus.swap_pending = pend_q;
endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// tb/tb_dot_matrix_scan_ctrl.sv - directed plus random checks of dot_matrix_scan_ctrl against a frame-level model
module tb_dot_matrix_scan_ctrl;
    localparam int ROWS          = 16;
    localparam int COLS          = 16;
    localparam int SCAN_DIV      = 4;
    localparam int SCROLL_FRAMES = 2;
    localparam int FRAME         = ROWS * SCAN_DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dot_matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    dot_matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .SCROLL_FRAMES(SCROLL_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int front_m [ROWS];
    int back_m  [ROWS];
    int pend_m, off_m, frames_m, fs_m, t_m;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_row();
        return (t_m / SCAN_DIV) % ROWS;
    endfunction

    function automatic int m_col();
        int src;
        int e;
        src = front_m[m_row()];
        e = 0;
        for (int i = 0; i < COLS; i++)
            if (((src >> ((i - off_m + COLS) % COLS)) & 1) != 0)
                e = e | (1 << i);
        return e;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) begin
            front_m[r] = 0;
            back_m[r]  = 0;
        end
        pend_m = 0; off_m = 0; frames_m = 0; fs_m = 0; t_m = 0;
    endtask

    task automatic model_update();
        bit boundary;
        int tmp;
        boundary = ((t_m % FRAME) == FRAME - 1);
        if (bus.wr_en && int'(bus.wr_row) < ROWS)
            back_m[int'(bus.wr_row)] = int'(bus.wr_data);
        if (boundary && pend_m != 0) begin
            for (int r = 0; r < ROWS; r++) begin
                tmp = front_m[r];
                front_m[r] = back_m[r];
                back_m[r] = tmp;
            end
            pend_m = 0;
        end else if (bus.commit) begin
            pend_m = 1;
        end
        if (boundary && bus.scroll_en) begin
            frames_m++;
            if (frames_m == SCROLL_FRAMES) begin
                frames_m = 0;
                off_m = bus.scroll_dir ? (off_m + COLS - 1) % COLS : (off_m + 1) % COLS;
            end
        end
        fs_m = boundary ? 1 : 0;
        t_m++;
    endtask

    task automatic check_all();
        chk("row_bin", int'(bus.row_bin), m_row());
        chk("row_sel", int'(bus.row_sel), 1 << m_row());
        chk("col", int'(bus.col), m_col());
        chk("frame_start", int'(bus.frame_start), fs_m);
        chk("swap_pending", int'(bus.swap_pending), pend_m);
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all();
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
    endtask

    task automatic run_to_row(input int r);
        for (int k = 0; k < FRAME && m_row() != r; k++) cycle();
    endtask

    task automatic wait_frames(input int n);
        int got;
        got = 0;
        for (int k = 0; k < n * FRAME + 8 && got < n; k++) begin
            cycle();
            if (bus.frame_start) got++;
        end
        chk("frame_wait", got, n);
    endtask

    task automatic write_row(input int r, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 4'(r);
        bus.wr_data = 16'(d);
        cycle();
    endtask

    initial begin
        int pulses;
        bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.commit = 1'b0;
        bus.scroll_en = 1'b0; bus.scroll_dir = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all();
        chk("rst_row_sel", int'(bus.row_sel), 16'h0001);
        chk("rst_col", int'(bus.col), 0);

        // idle scan and frame pulse spacing
        repeat (4) cycle();
        chk("row_after4", int'(bus.row_bin), 1);
        chk("sel_after4", int'(bus.row_sel), 16'h0002);
        pulses = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            cycle();
            if (bus.frame_start) begin
                pulses++;
                chk("fs_row0", int'(bus.row_bin), 0);
            end
        end
        chk("fs_count", pulses, 2);

        // write + commit mid-frame
        write_row(3, 16'hF00F);
        bus.commit = 1'b1; cycle();
        chk("pending_set", int'(bus.swap_pending), 1);
        run_to_row(15);
        chk("hidden_until_swap", int'(bus.col), 0);
        wait_frames(1);
        chk("pending_clr", int'(bus.swap_pending), 0);
        run_to_row(3);
        chk("row3_f00f", int'(bus.col), 16'hF00F);
        run_to_row(4);
        chk("row4_blank", int'(bus.col), 0);

        // buffer isolation and double commit
        write_row(3, 16'h1234);
        wait_frames(2);
        run_to_row(3);
        chk("isolated", int'(bus.col), 16'hF00F);
        bus.commit = 1'b1; cycle();
        bus.commit = 1'b1; cycle();
        wait_frames(1);
        run_to_row(3);
        chk("row3_1234", int'(bus.col), 16'h1234);
        wait_frames(1);
        run_to_row(3);
        chk("single_swap", int'(bus.col), 16'h1234);
        bus.commit = 1'b1; cycle();
        wait_frames(1);
        run_to_row(3);
        chk("back_to_f00f", int'(bus.col), 16'hF00F);

        // scrolling, both directions, full wrap
        wait_frames(1);
        bus.scroll_en = 1'b1; bus.scroll_dir = 1'b0;
        wait_frames(2);
        run_to_row(3);
        chk("scroll_left1", int'(bus.col), 16'hE01F);
        wait_frames(30);
        run_to_row(3);
        chk("scroll_wrap", int'(bus.col), 16'hF00F);
        bus.scroll_dir = 1'b1;
        wait_frames(2);
        run_to_row(3);
        chk("scroll_right1", int'(bus.col), 16'hF807);
        bus.scroll_en = 1'b0;

        // commit and write on the frame-boundary cycle
        for (int k = 0; k < FRAME && (t_m % FRAME) != FRAME - 1; k++) cycle();
        bus.commit = 1'b1;
        bus.wr_en = 1'b1; bus.wr_row = 4'd5; bus.wr_data = 16'hAAAA;
        cycle();
        chk("coll_fs", int'(bus.frame_start), 1);
        chk("coll_pending", int'(bus.swap_pending), 1);
        run_to_row(5);
        chk("coll_no_swap", int'(bus.col), 0);
        wait_frames(1);
        run_to_row(5);
        chk("coll_swapped", int'(bus.col), 16'h5555);
        chk("coll_pend_clr", int'(bus.swap_pending), 0);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            if (k % 200 == 0) begin
                bus.scroll_en  = 1'($urandom_range(0, 1));
                bus.scroll_dir = 1'($urandom_range(0, 1));
            end
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_row  = 4'($urandom_range(0, ROWS - 1));
            bus.wr_data = 16'($urandom);
            bus.commit  = ($urandom_range(0, 49) == 0);
            cycle();
        end

        // async reset mid-frame while scrolling
        bus.scroll_en = 1'b0;
        write_row(3, 16'hF00F);
        bus.commit = 1'b1; cycle();
        wait_frames(2);
        bus.scroll_en = 1'b1; bus.scroll_dir = 1'b0;
        wait_frames(2);
        run_to_row(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_row", int'(bus.row_bin), 0);
        chk("arst_sel", int'(bus.row_sel), 16'h0001);
        chk("arst_col", int'(bus.col), 0);
        chk("arst_pend", int'(bus.swap_pending), 0);
        chk("arst_fs", int'(bus.frame_start), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all();
        run_to_row(3);
        chk("post_rst_blank", int'(bus.col), 0);
        bus.scroll_en = 1'b0;
        write_row(3, 16'hF00F);
        bus.commit = 1'b1; cycle();
        wait_frames(1);
        run_to_row(3);
        chk("post_rst_off0", int'(bus.col), 16'hF00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
